nibble_serial_addsub_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add or subtract by time-multiplexing one internal 4-bit add/sub slice over WIDTH/4 nibbles, least significant nibble first. The carry is chained through a register between nibbles.
- Slice behaviour: operand b is XORed with the mode bit, and the carry-in of nibble 0 is the mode bit.
- Used wherever a wide add/sub is needed and area matters more than latency.
- Interface is a start/busy/done handshake.

---
 rtl/nibble_serial_addsub_ctrl_if.sv | 24 ++
 rtl/nibble_serial_addsub_ctrl.sv | 111 +++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Start/busy/done handshake bundle for the nibble-serial add/sub sequencer.
interface nibble_serial_addsub_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ov;

    modport master (
        output start, m, a, b,
        input  busy, done, s, cout, ov
    );

    modport slave (
        input  start, m, a, b,
        output busy, done, s, cout, ov
    );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract computed by one 4-bit slice reused over WIDTH/4 cycles,
// least significant nibble first, carry chained through a register.
module nibble_serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    nibble_serial_addsub_ctrl_if.slave    bus
);
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned SH_W  = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             m_q, m_d, carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cout_q, cout_d, ov_q, ov_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [SH_W-1:0]  sh;
    logic [3:0]       nib_a, nib_x;
    logic [4:0]       sum5;
    logic             c3, c4, last;

    // Shared 4-bit slice operating on the nibble selected by idx
    always_comb begin
        sh    = {idx_q, 2'b00};
        nib_a = 4'(a_q >> sh);
        nib_x = 4'(b_q >> sh) ^ {4{m_q}};
        sum5  = 5'(nib_a) + 5'(nib_x) + 5'(carry_q);
        c4    = sum5[4];
        c3    = nib_a[3] ^ nib_x[3] ^ sum5[3];
        last  = (idx_q == IDX_W'(NIB - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    m_d     = bus.m;
                    carry_d = bus.m;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = (s_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(sum5[3:0]) << sh);
                carry_d = c4;
                if (last) begin
                    cout_d  = c4;
                    ov_d    = c3 ^ c4;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ov   = ov_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for nibble_serial_addsub_ctrl (WIDTH=16): directed table, random ops, corner sequences.
module tb_nibble_serial_addsub_ctrl;
    localparam int unsigned WIDTH = 16;
    localparam int          LAT   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    nibble_serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             m;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] es;
        logic             ecout;
        logic             eov;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ov;
    } res_t;

    // Reference: whole-word two's-complement arithmetic, b inverted and carry-in = m for subtract
    function automatic res_t model(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t             r;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb     = m ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, m};
        r.s    = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ov   = (a[WIDTH-1] == bb[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive start for one edge; returns right after the accepting edge
    task automatic do_start(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.m     = m;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Cycle count (1 = first cycle after accepting edge) at which done is seen, -1 on timeout
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_check(input string name, input logic m, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] es,
                             input logic ecout, input logic eov);
        int lat;
        do_start(m, a, b);
        wait_done(lat);
        chk({name, " latency"}, 32'(lat), 32'(LAT));
        if (lat > 0) begin
            chk({name, " s"}, 32'(bus.s), 32'(es));
            chk({name, " cout"}, 32'(bus.cout), 32'(ecout));
            chk({name, " ov"}, 32'(bus.ov), 32'(eov));
            chk({name, " busy_at_done"}, 32'(bus.busy), 32'd1);
            @(negedge clk);
            chk({name, " busy_after"}, 32'(bus.busy), 32'd0);
            chk({name, " done_after"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs[$];
        res_t r;
        int   lat;
        int   dones;
        logic m;
        logic [WIDTH-1:0] a, b;

        vecs.push_back('{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0});

        bus.start = 1'b0;
        bus.m     = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset s", 32'(bus.s), 32'd0);
        chk("reset cout", 32'(bus.cout), 32'd0);
        chk("reset ov", 32'(bus.ov), 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b,
                      vecs[i].es, vecs[i].ecout, vecs[i].eov);

        for (int i = 0; i < 30; i++) begin
            m = 1'($urandom);
            a = WIDTH'($urandom);
            b = (i % 7 == 0) ? a : WIDTH'($urandom);
            r = model(m, a, b);
            run_check($sformatf("rnd%0d", i), m, a, b, r.s, r.cout, r.ov);
        end

        // Restart attempts in RUN and in DONE must be ignored; first IDLE cycle accepts
        do_start(1'b0, 16'hFFFF, 16'h0001);
        dones = 0;
        lat   = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                if (lat < 0) lat = k;
            end
            if (k == 2 || k == 5) begin
                bus.start = 1'b1;
                bus.m     = 1'b1;
                bus.a     = 16'h1111;
                bus.b     = 16'h1111;
            end
            if (k == 6) begin
                chk("restart idle busy", 32'(bus.busy), 32'd0);
                chk("restart s kept", 32'(bus.s), 32'h0000);
                chk("restart cout kept", 32'(bus.cout), 32'd1);
                bus.start = 1'b1;
                bus.m     = 1'b0;
                bus.a     = 16'h1111;
                bus.b     = 16'h1111;
            end
        end
        chk("restart done count", 32'(dones), 32'd1);
        chk("restart latency", 32'(lat), 32'(LAT));
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
        chk("accept after done latency", 32'(lat), 32'(LAT));
        chk("accept after done s", 32'(bus.s), 32'h2222);

        // Reset during the second RUN cycle
        do_start(1'b0, 16'h1234, 16'h5678);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst s", 32'(bus.s), 32'd0);
        chk("midrst cout", 32'(bus.cout), 32'd0);
        chk("midrst ov", 32'(bus.ov), 32'd0);
        run_check("post reset", 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
